// File: rtl/instr_fetch_unit_pkg.sv
// instr_fetch_unit_pkg: shared constants for the fetch stage.
// Contents: fetch FSM state encodings, RISC-V instruction field positions,
// default reset PC.
package instr_fetch_unit_pkg;
    localparam logic [1:0] S_BOOT  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int OPC_LSB = 0;
    localparam int OPC_MSB = 6;
    localparam int F3_LSB  = 12;
    localparam int F3_MSB  = 14;
    localparam int F7_BIT  = 30;
endpackage

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// instr_fetch_unit_fetch_fifo: DEPTH x W instruction buffer with flush.
// Ports: clk, rst_n (async, active low), push/din write, pop/dout head read,
// flush empties the buffer, count/empty/full status.
module instr_fetch_unit_fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd, wr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd    <= '0;
            wr    <= '0;
            count <= '0;
        end else if (flush) begin
            rd    <= '0;
            wr    <= '0;
            count <= '0;
        end else begin
            if (push) wr <= wr + 1'b1;
            if (pop) rd <= rd + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr] <= din;
    end

    assign dout  = mem[rd];
    assign empty = count == '0;
    assign full  = count == (AW+1)'(DEPTH);
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC, in-order imem requests, instruction buffer, redirect/flush.
// Ports: clk, rst_n (async, active low); imem_req_* request channel,
// imem_rsp_* response channel; dec_valid/dec_ready with Instr, PC and
// opcode/func3/func7 slices to decode; PCSrc, branch_pc, ImmExt redirect.
// Optional macro FETCH_PERF_EN adds perf_fetched and perf_flushes counters.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(RESET_PC_DEFAULT),
    parameter int                FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [31:0]       imem_rsp_data,
    output logic              dec_valid,
    input  logic              dec_ready,
    output logic [31:0]       Instr,
    output logic [ADDR_W-1:0] PC,
    output logic [6:0]        opcode,
    output logic [2:0]        func3,
    output logic              func7,
    input  logic              PCSrc,
    input  logic [ADDR_W-1:0] branch_pc,
`ifdef FETCH_PERF_EN
    input  logic [ADDR_W-1:0] ImmExt,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_flushes
`else
    input  logic [ADDR_W-1:0] ImmExt
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int W  = 32 + ADDR_W;

    logic [1:0]        state, state_nxt;
    logic [ADDR_W-1:0] fetch_pc, rsp_pc, sum, target;
    logic [CW-1:0]     outstanding, drop_cnt, out_nxt, drop_nxt, count;
    logic [W-1:0]      head;
    logic              accept, push, pop, empty, full;

    always_comb begin
        sum            = branch_pc + ImmExt;
        target         = {sum[ADDR_W-1:2], 2'b00};
        // Credit rule: words in flight plus buffered words never exceed the buffer.
        imem_req_valid = state == S_RUN && !PCSrc &&
                         ({1'b0, outstanding} + {1'b0, count}) < (CW+1)'(FIFO_DEPTH);
        imem_req_addr  = fetch_pc;
        accept         = imem_req_valid && imem_req_ready;
        push           = imem_rsp_valid && drop_cnt == '0 && !PCSrc && !full;
        dec_valid      = !empty;
        pop            = dec_valid && dec_ready && !PCSrc;
        out_nxt        = outstanding + CW'(accept) - CW'(imem_rsp_valid);
        drop_nxt       = PCSrc ? out_nxt :
                         (imem_rsp_valid && drop_cnt != '0) ? drop_cnt - 1'b1 : drop_cnt;
        state_nxt      = PCSrc ? (out_nxt != '0 ? S_DRAIN : S_RUN) :
                         state == S_BOOT ? S_RUN :
                         (state == S_DRAIN && drop_nxt == '0) ? S_RUN : state;
        Instr          = dec_valid ? head[31:0] : '0;
        PC             = dec_valid ? head[32 +: ADDR_W] : '0;
        opcode         = Instr[OPC_MSB:OPC_LSB];
        func3          = Instr[F3_MSB:F3_LSB];
        func7          = Instr[F7_BIT];
    end

    // Responses are in order and every word issued before a redirect is dropped,
    // so the PC of each kept word is the target plus 4 per word kept since.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_BOOT;
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            state       <= state_nxt;
            outstanding <= out_nxt;
            drop_cnt    <= drop_nxt;
            fetch_pc    <= PCSrc ? target : accept ? fetch_pc + ADDR_W'(4) : fetch_pc;
            rsp_pc      <= PCSrc ? target : push ? rsp_pc + ADDR_W'(4) : rsp_pc;
        end
    end

    instr_fetch_unit_fetch_fifo #(.DEPTH(FIFO_DEPTH), .W(W)) u_fetch_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (PCSrc),
        .din   ({rsp_pc, imem_rsp_data}),
        .dout  (head),
        .count (count),
        .empty (empty),
        .full  (full)
    );

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched <= '0;
            perf_flushes <= '0;
        end else begin
            perf_fetched <= perf_fetched + 32'(push);
            perf_flushes <= perf_flushes + 32'(PCSrc);
        end
    end
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: scoreboard bench for instr_fetch_unit with a latency-configurable memory.
module tb_instr_fetch_unit;
    logic        clk = 1'b0, rst_n = 1'b1;
    logic        imem_req_valid, imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        dec_valid, dec_ready = 1'b1;
    logic [31:0] Instr, PC;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic        func7;
    logic        PCSrc = 1'b0;
    logic [31:0] branch_pc = '0, ImmExt = '0;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_flushes;
`endif

    instr_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .Instr          (Instr),
        .PC             (PC),
        .opcode         (opcode),
        .func3          (func3),
        .func7          (func7),
        .PCSrc          (PCSrc),
        .branch_pc      (branch_pc),
`ifdef FETCH_PERF_EN
        .perf_fetched   (perf_fetched),
        .perf_flushes   (perf_flushes),
`endif
        .ImmExt         (ImmExt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    logic [31:0] exp_q[$];
    int          n_cmp = 0, n_bad = 0, cyc = 0, lat = 1, deliv = 0, acc_cnt = 0;
    int          first_acc = -1, first_dv = -1;
    bit          rnd_ready = 0, rnd_dec = 0, redir = 0;
    logic [31:0] exp_fetch = '0, last_pc = '0;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h0101_0103) ^ 32'h4B1D_C0DE;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        PCSrc = 1'b0;
        redir = 0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = '0;
        mq.delete();
        exp_q.delete();
        exp_fetch = 32'h0;
        first_acc = -1;
        first_dv = -1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock: drive inputs at the falling edge, observe settled outputs,
    // update memory model and scoreboard, then wait for the next falling edge.
    task automatic tick();
        bit          rsp_now, acc, popd;
        logic [31:0] e, wd;
        if (rnd_ready) imem_req_ready = 1'($urandom_range(0, 1));
        else imem_req_ready = 1'b1;
        if (rnd_dec) dec_ready = 1'($urandom_range(0, 1));
        rsp_now = mq.size() > 0 && mq[0].due <= cyc;
        imem_rsp_valid = rsp_now;
        imem_rsp_data = rsp_now ? word_of(mq[0].addr) : 32'h0;
        PCSrc = redir;
        #1;
        acc = imem_req_valid && imem_req_ready;
        popd = dec_valid && dec_ready && !PCSrc;
        if (dec_valid && first_dv < 0) first_dv = cyc;
        if (popd) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_dec: got PC=%h with no pending entry, want none", PC);
            end else begin
                e = exp_q.pop_front();
                wd = word_of(e);
                if (PC !== e) begin
                    n_bad++;
                    $display("FAIL dec_pc: got %h want %h", PC, e);
                end
                n_cmp++;
                if (Instr !== wd) begin
                    n_bad++;
                    $display("FAIL dec_instr: got %h want %h", Instr, wd);
                end
                n_cmp++;
                if ({opcode, func3, func7} !== {wd[6:0], wd[14:12], wd[30]}) begin
                    n_bad++;
                    $display("FAIL dec_fields: got %h/%h/%b want %h/%h/%b",
                             opcode, func3, func7, wd[6:0], wd[14:12], wd[30]);
                end
                deliv++;
                last_pc = PC;
            end
        end
        if (PCSrc) begin
            n_cmp++;
            if (imem_req_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL req_during_redirect: got %b want 0", imem_req_valid);
            end
            exp_q.delete();
            exp_fetch = (branch_pc + ImmExt) & 32'hFFFF_FFFC;
        end
        if (acc) begin
            n_cmp++;
            if (imem_req_addr !== exp_fetch) begin
                n_bad++;
                $display("FAIL req_addr: got %h want %h", imem_req_addr, exp_fetch);
            end
            mq.push_back('{addr: imem_req_addr, due: cyc + lat});
            exp_q.push_back(exp_fetch);
            exp_fetch += 32'd4;
            acc_cnt++;
            if (first_acc < 0) first_acc = cyc;
        end
        if (rsp_now) void'(mq.pop_front());
        redir = 0;
        @(negedge clk);
        cyc++;
    endtask

    task automatic wait_deliv(input logic [31:0] want, input string name);
        int d0 = deliv;
        for (int i = 0; i < 40 && deliv == d0; i++) tick();
        n_cmp++;
        if (deliv == d0) begin
            n_bad++;
            $display("FAIL %s_timeout: got no delivery want PC %h", name, want);
        end else if (last_pc !== want) begin
            n_bad++;
            $display("FAIL %s_first_pc: got %h want %h", name, last_pc, want);
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({imem_req_valid, dec_valid} !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_valids: got %b%b want 00", imem_req_valid, dec_valid);
        end
        n_cmp++;
        if ({Instr, PC} !== 64'h0) begin
            n_bad++;
            $display("FAIL reset_instr_pc: got %h/%h want 0/0", Instr, PC);
        end
`ifdef FETCH_PERF_EN
        n_cmp++;
        if ({perf_fetched, perf_flushes} !== 64'h0) begin
            n_bad++;
            $display("FAIL reset_perf: got %h/%h want 0/0", perf_fetched, perf_flushes);
        end
`endif
        do_reset();
        #1;
        n_cmp++;
        if (imem_req_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL boot_no_req: got %b want 0", imem_req_valid);
        end
        tick();
        n_cmp++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
            n_bad++;
            $display("FAIL run_first_req: got %b@%h want 1@00000000", imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_stream();
        int d0 = deliv;
        lat = 1;
        dec_ready = 1'b1;
        repeat (12) tick();
        n_cmp++;
        if (first_acc < 0 || first_dv - first_acc != 2) begin
            n_bad++;
            $display("FAIL fetch_latency: got %0d cycles want 2", first_dv - first_acc);
        end
        n_cmp++;
        if (deliv - d0 < 4) begin
            n_bad++;
            $display("FAIL stream_count: got %0d want >=4", deliv - d0);
        end
    endtask

    task automatic test_stall();
        int a0 = acc_cnt;
        dec_ready = 1'b0;
        repeat (10) tick();
        n_cmp++;
        if (acc_cnt - a0 > 2) begin
            n_bad++;
            $display("FAIL stall_accepts: got %0d want <=2", acc_cnt - a0);
        end
        n_cmp++;
        if ({imem_req_valid, dec_valid} !== 2'b01) begin
            n_bad++;
            $display("FAIL stall_valids: got %b%b want 01", imem_req_valid, dec_valid);
        end
        n_cmp++;
        if (exp_q.size() != 2) begin
            n_bad++;
            $display("FAIL stall_held: got %0d pending want 2", exp_q.size());
        end
        dec_ready = 1'b1;
        repeat (8) tick();
    endtask

    task automatic test_redirect();
        do_reset();
        lat = 3;
        dec_ready = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if (mq.size() != 2) begin
            n_bad++;
            $display("FAIL redirect_setup: got %0d outstanding want 2", mq.size());
        end
        branch_pc = 32'h10;
        ImmExt = 32'hFFFF_FFF8;
        redir = 1;
        tick();
        n_cmp++;
        if ({imem_req_valid, dec_valid} !== 2'b00) begin
            n_bad++;
            $display("FAIL drain_1: got %b%b want 00", imem_req_valid, dec_valid);
        end
        tick();
        n_cmp++;
        if ({imem_req_valid, dec_valid} !== 2'b00) begin
            n_bad++;
            $display("FAIL drain_2: got %b%b want 00", imem_req_valid, dec_valid);
        end
        tick();
        n_cmp++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8) begin
            n_bad++;
            $display("FAIL after_drain_req: got %b@%h want 1@00000008", imem_req_valid, imem_req_addr);
        end
        wait_deliv(32'h8, "redirect");
    endtask

    task automatic test_coincident();
        int i;
`ifdef FETCH_PERF_EN
        logic [31:0] fl0;
`endif
        lat = 1;
        dec_ready = 1'b1;
        for (i = 0; i < 30; i++) begin
            if (dec_valid && mq.size() > 0 && mq[0].due <= cyc) break;
            tick();
        end
        n_cmp++;
        if (i == 30) begin
            n_bad++;
            $display("FAIL coincident_setup: got no pop+response cycle want one");
        end
`ifdef FETCH_PERF_EN
        fl0 = perf_flushes;
`endif
        branch_pc = 32'h100;
        ImmExt = 32'h22;
        redir = 1;
        tick();
`ifdef FETCH_PERF_EN
        n_cmp++;
        if (perf_flushes !== fl0 + 32'd1) begin
            n_bad++;
            $display("FAIL perf_flushes: got %0d want %0d", perf_flushes, fl0 + 32'd1);
        end
`endif
        wait_deliv(32'h120, "coincident");
    endtask

    task automatic test_wrap();
        int d0;
        lat = 1;
        dec_ready = 1'b1;
        branch_pc = 32'hFFFF_FFF4;
        ImmExt = 32'h4;
        redir = 1;
        tick();
        wait_deliv(32'hFFFF_FFF8, "wrap");
        d0 = deliv;
        repeat (12) tick();
        n_cmp++;
        if (deliv - d0 < 3) begin
            n_bad++;
            $display("FAIL wrap_count: got %0d want >=3", deliv - d0);
        end
    endtask

    task automatic test_random();
        int d0 = deliv;
        lat = 3;
        rnd_ready = 1;
        rnd_dec = 1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                branch_pc = $urandom;
                ImmExt = $urandom_range(0, 255);
                redir = 1;
            end
            tick();
        end
        rnd_ready = 0;
        rnd_dec = 0;
        dec_ready = 1'b1;
        repeat (20) tick();
        n_cmp++;
        if (deliv - d0 < 20) begin
            n_bad++;
            $display("FAIL random_count: got %0d want >=20", deliv - d0);
        end
    endtask

    task automatic test_midreset();
        lat = 1;
        dec_ready = 1'b0;
        repeat (6) tick();
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({imem_req_valid, dec_valid} !== 2'b00 || {Instr, PC} !== 64'h0) begin
            n_bad++;
            $display("FAIL midreset_outputs: got %b%b %h/%h want 00 0/0",
                     imem_req_valid, dec_valid, Instr, PC);
        end
`ifdef FETCH_PERF_EN
        n_cmp++;
        if ({perf_fetched, perf_flushes} !== 64'h0) begin
            n_bad++;
            $display("FAIL midreset_perf: got %h/%h want 0/0", perf_fetched, perf_flushes);
        end
`endif
        @(negedge clk);
        dec_ready = 1'b1;
        do_reset();
        wait_deliv(32'h0, "restart");
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_coincident();
        test_wrap();
        test_random();
        test_midreset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch stage directly upstream of the control unit. Holds the PC, issues in-order requests to instruction memory, buffers returned words in a small FIFO, and presents Instr/PC plus pre-sliced opcode/func3/func7 to decode. Consumes PCSrc and the branch target from the execute/branch path to redirect and flush.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
FIFO_DEPTH, 2, instruction buffer entries (power of two, >=2)
ADDR_W, 32, address/PC width

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous reset, active low
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  ADDR_W  word-aligned fetch address
imem_rsp_valid  in  1  response word valid, in-order, >=1 cycle after accept
imem_rsp_data  in  32  instruction word
dec_valid  out  1  Instr/PC valid to decode
dec_ready  in  1  decode consumes head entry
Instr  out  32  head instruction
PC  out  ADDR_W  PC of head instruction
opcode  out  7  Instr[6:0]
func3  out  3  Instr[14:12]
func7  out  1  Instr[30]
PCSrc  in  1  taken branch/jump redirect request
branch_pc  in  ADDR_W  PC of redirecting instruction
ImmExt  in  ADDR_W  sign-extended offset; target = branch_pc + ImmExt, modulo 2^ADDR_W

Behaviour:
- Reset (async, rst_n=0): fetch_pc=RESET_PC, FIFO empty, outstanding=0, drop_cnt=0, state=S_BOOT; imem_req_valid=0, dec_valid=0, Instr=0, PC=0.
- FSM: S_BOOT -> S_RUN unconditionally one cycle after reset release (no request in S_BOOT).
- S_RUN: imem_req_valid=1 when outstanding + fifo_count < FIFO_DEPTH (credit rule guarantees FIFO never overflows); addr=fetch_pc; on valid&ready: fetch_pc+=4, outstanding+=1.
- Response: outstanding-=1; if drop_cnt>0 word discarded and drop_cnt-=1, else pushed with its PC (PC FIFO runs alongside, captured at request).
- Decode: dec_valid = FIFO non-empty; head pops on dec_valid&dec_ready. Fetch-to-dec_valid latency min 2 cycles after request accept with 1-cycle memory.
- Redirect (PCSrc=1, any state): same edge: FIFO flushed, fetch_pc=target, drop_cnt = outstanding after this cycle's accept/response updates (response arriving same cycle is discarded; request accepted same cycle is counted); no request issued this cycle (imem_req_valid forced 0). Next state S_DRAIN if drop_cnt>0 else S_RUN.
- S_DRAIN: no requests; dec_valid=0; -> S_RUN when drop_cnt reaches 0. A new PCSrc in S_DRAIN reloads target, drop_cnt unchanged logic as above.
- Redirect wins over pop: head is not counted as consumed if PCSrc and pop coincide.
- Simultaneous push and pop on full FIFO is legal only under credit rule (cannot occur beyond capacity).
- fetch_pc wraps modulo 2^ADDR_W. target[1:0] ignored (forced 00).
- Reset mid-transaction: all state cleared; in-flight responses after reset must not arrive (memory reset by same rst_n).

Optional Feature:
FETCH_PERF_EN: defined -> adds outputs perf_fetched[31:0] (words pushed to FIFO) and perf_flushes[31:0] (PCSrc cycles), both reset 0, wrapping. Undefined -> ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package/header: fetch FSM state encodings (S_BOOT, S_RUN, S_DRAIN), RISC-V field bit positions, RESET_PC default.
- One sub-module: fetch_fifo (parameterized FIFO_DEPTH x (32+ADDR_W), push/pop/flush, count, empty/full).

Test Plan:
- Reset release, ready=1, 1-cycle memory, dec_ready=1 -> requests at 0x0,0x4,0x8...; first dec_valid with PC=0x0 two cycles after first accept; opcode/func3/func7 match Instr slices.
- dec_ready=0 -> at most FIFO_DEPTH accepted requests, imem_req_valid drops, no word lost; release -> in-order PCs.
- PCSrc=1, branch_pc=0x10, ImmExt=0xFFFF_FFF8 with 2 outstanding -> FIFO flushed, S_DRAIN, 2 responses discarded, next request addr 0x8.
- PCSrc coincident with response arrival and dec pop -> response dropped, popped entry not delivered, next dec PC = target.
- imem_req_ready toggling randomly, 3-cycle response latency -> PC sequence contiguous, no duplicates or gaps.
- rst_n asserted mid-stream -> outputs zero immediately (async); after release restart from RESET_PC; with FETCH_PERF_EN counters reset to 0.
